// File: rtl/bank_cmd_arbiter.sv
// Round-robin arbiter that merges per-bank DRAM commands and refresh into one
// registered command stream, enforcing tRRD/tCCD/tWTR/tRTW before each grant.
module bank_cmd_arbiter #(
    parameter int NUM_BANKS = 8,
    parameter int BA_W      = 3,
    parameter int ADDR_W    = 24,
    parameter int T_RRD     = 4,
    parameter int T_CCD     = 4,
    parameter int T_WTR     = 6,
    parameter int T_RTW     = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_BANKS-1:0]        req_valid,
    input  logic [4*NUM_BANKS-1:0]      req_cmd,
    input  logic [ADDR_W*NUM_BANKS-1:0] req_addr,
    output logic [NUM_BANKS-1:0]        req_grant,
    input  logic                        ref_req,
    output logic                        ref_grant,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [3:0]                  out_cmd,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [BA_W-1:0]             out_bank
);

    localparam logic [3:0] CMD_READ    = 4'd1;
    localparam logic [3:0] CMD_WRITE   = 4'd2;
    localparam logic [3:0] CMD_REFRESH = 4'd5;
    localparam logic [3:0] CMD_ACTIVE  = 4'd6;
    localparam logic [3:0] CMD_PRE     = 4'd7;

    localparam int TW = 8;
    // A timer loaded in grant cycle N reads T-1 in N+1 and hits zero in N+T,
    // so the class is eligible again exactly T cycles after its grant.
    localparam logic [TW-1:0] LD_RRD = TW'((T_RRD > 0) ? T_RRD - 1 : 0);
    localparam logic [TW-1:0] LD_CCD = TW'((T_CCD > 0) ? T_CCD - 1 : 0);
    localparam logic [TW-1:0] LD_WTR = TW'((T_WTR > 0) ? T_WTR - 1 : 0);
    localparam logic [TW-1:0] LD_RTW = TW'((T_RTW > 0) ? T_RTW - 1 : 0);

    logic [TW-1:0]     act_t_q, act_t_d, ccd_t_q, ccd_t_d;
    logic [TW-1:0]     wtr_t_q, wtr_t_d, rtw_t_q, rtw_t_d;
    logic [BA_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_cmd_q, out_cmd_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [BA_W-1:0]   out_bank_q, out_bank_d;

    logic [NUM_BANKS-1:0] elig;
    logic [NUM_BANKS-1:0] grant_vec;
    logic                 free, timers_clr, ref_go, found;
    logic [BA_W-1:0]      sel, idx;
    logic [3:0]           sel_cmd;
    logic [ADDR_W-1:0]    sel_addr;

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_elig
            logic [3:0] cmd;
            assign cmd = req_cmd[4*gi +: 4];
            always_comb begin
                case (cmd)
                    CMD_ACTIVE: elig[gi] = req_valid[gi] && (act_t_q == '0);
                    CMD_READ:   elig[gi] = req_valid[gi] && (ccd_t_q == '0) && (wtr_t_q == '0);
                    CMD_WRITE:  elig[gi] = req_valid[gi] && (ccd_t_q == '0) && (rtw_t_q == '0);
                    CMD_PRE:    elig[gi] = req_valid[gi];
                    default:    elig[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    always_comb begin
        free       = !out_valid_q || out_ready;
        timers_clr = (act_t_q == '0) && (ccd_t_q == '0) && (wtr_t_q == '0) && (rtw_t_q == '0);
        ref_go     = rst_n && ref_req && free && timers_clr;

        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            idx = rr_ptr_q + BA_W'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        sel_cmd  = req_cmd[{sel, 2'b00} +: 4];
        sel_addr = req_addr[int'(sel) * ADDR_W +: ADDR_W];

        grant_vec = '0;
        if (rst_n && !ref_req && free && found) grant_vec[sel] = 1'b1;

        act_t_d = (act_t_q != '0) ? act_t_q - 1'b1 : act_t_q;
        ccd_t_d = (ccd_t_q != '0) ? ccd_t_q - 1'b1 : ccd_t_q;
        wtr_t_d = (wtr_t_q != '0) ? wtr_t_q - 1'b1 : wtr_t_q;
        rtw_t_d = (rtw_t_q != '0) ? rtw_t_q - 1'b1 : rtw_t_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q && !out_ready;
        out_cmd_d   = out_cmd_q;
        out_addr_d  = out_addr_q;
        out_bank_d  = out_bank_q;

        if (ref_go) begin
            out_valid_d = 1'b1;
            out_cmd_d   = CMD_REFRESH;
            out_addr_d  = '0;
            out_bank_d  = '0;
            act_t_d     = LD_RRD;
        end else if (grant_vec != '0) begin
            out_valid_d = 1'b1;
            out_cmd_d   = sel_cmd;
            out_addr_d  = sel_addr;
            out_bank_d  = sel;
            rr_ptr_d    = sel + 1'b1;
            case (sel_cmd)
                CMD_ACTIVE: act_t_d = LD_RRD;
                CMD_READ: begin
                    ccd_t_d = LD_CCD;
                    rtw_t_d = LD_RTW;
                end
                CMD_WRITE: begin
                    ccd_t_d = LD_CCD;
                    wtr_t_d = LD_WTR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_t_q     <= '0;
            ccd_t_q     <= '0;
            wtr_t_q     <= '0;
            rtw_t_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_cmd_q   <= '0;
            out_addr_q  <= '0;
            out_bank_q  <= '0;
        end else begin
            act_t_q     <= act_t_d;
            ccd_t_q     <= ccd_t_d;
            wtr_t_q     <= wtr_t_d;
            rtw_t_q     <= rtw_t_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_cmd_q   <= out_cmd_d;
            out_addr_q  <= out_addr_d;
            out_bank_q  <= out_bank_d;
        end
    end

    assign req_grant = grant_vec;
    assign ref_grant = ref_go;
    assign out_valid = out_valid_q;
    assign out_cmd   = out_cmd_q;
    assign out_addr  = out_addr_q;
    assign out_bank  = out_bank_q;

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: directed timing scenarios plus randomized traffic,
// checked every cycle against a grant-timestamp reference model.
module tb_bank_cmd_arbiter;

    localparam int NB = 8;
    localparam int AW = 24;
    localparam int T_RRD = 4, T_CCD = 4, T_WTR = 6, T_RTW = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NB-1:0]     req_valid = '0;
    logic [4*NB-1:0]   req_cmd = '0;
    logic [AW*NB-1:0]  req_addr = '0;
    logic [NB-1:0]     req_grant;
    logic              ref_req = 1'b0;
    logic              ref_grant;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [3:0]        out_cmd;
    logic [AW-1:0]     out_addr;
    logic [2:0]        out_bank;

    bank_cmd_arbiter #(.NUM_BANKS(NB), .BA_W(3), .ADDR_W(AW), .T_RRD(T_RRD),
                       .T_CCD(T_CCD), .T_WTR(T_WTR), .T_RTW(T_RTW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_grant(req_grant), .ref_req(ref_req),
        .ref_grant(ref_grant), .out_valid(out_valid), .out_ready(out_ready),
        .out_cmd(out_cmd), .out_addr(out_addr), .out_bank(out_bank));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: remembers the cycle of the last grant of each class.
    int        cyc = 0;
    int        last_act, last_col, last_wr, last_rd;
    bit        m_valid;
    logic [3:0]    m_cmd;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_bank;
    int        m_rr;
    logic [NB-1:0] gnt_seen;
    logic          ref_seen;
    int            gcyc;

    task automatic model_reset();
        last_act = -1000; last_col = -1000; last_wr = -1000; last_rd = -1000;
        m_valid = 0; m_cmd = 0; m_addr = 0; m_bank = 0; m_rr = 0;
    endtask

    function automatic bit m_elig(logic [3:0] c);
        bit col_ok = (cyc - last_col >= T_CCD);
        case (c)
            4'd6:    return (cyc - last_act >= T_RRD);
            4'd1:    return col_ok && (cyc - last_wr >= T_WTR);
            4'd2:    return col_ok && (cyc - last_rd >= T_RTW);
            4'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(int b, bit v, logic [3:0] c, logic [AW-1:0] a);
        req_valid[b]        = v;
        req_cmd[4*b +: 4]   = c;
        req_addr[AW*b +: AW] = a;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit free, exp_ref, all_clr;
        logic [NB-1:0] exp_gnt;
        int b, sb;
        @(negedge clk);
        free    = !m_valid || out_ready;
        all_clr = (cyc - last_act >= T_RRD) && (cyc - last_col >= T_CCD) &&
                  (cyc - last_wr >= T_WTR) && (cyc - last_rd >= T_RTW);
        exp_ref = ref_req && free && all_clr;
        exp_gnt = '0;
        sb = -1;
        if (!ref_req && free) begin
            for (int k = 0; k < NB; k++) begin
                b = (m_rr + k) % NB;
                if (sb < 0 && req_valid[b] && m_elig(req_cmd[4*b +: 4])) sb = b;
            end
            if (sb >= 0) exp_gnt[sb] = 1'b1;
        end
        chk("req_grant", 32'(req_grant), 32'(exp_gnt));
        chk("ref_grant", 32'(ref_grant), 32'(exp_ref));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_cmd", 32'(out_cmd), 32'(m_cmd));
            chk("out_addr", 32'(out_addr), 32'(m_addr));
            chk("out_bank", 32'(out_bank), 32'(m_bank));
        end
        gnt_seen = req_grant;
        ref_seen = ref_grant;
        gcyc     = cyc;
        $display("cyc=%0d rdy=%0b ref=%0b gnt=%b rgnt=%0b out v=%0b cmd=%0d bank=%0d addr=%0h",
                 cyc, out_ready, ref_req, req_grant, ref_grant, out_valid, out_cmd, out_bank, out_addr);
        @(posedge clk);
        if (exp_ref) begin
            m_valid = 1; m_cmd = 4'd5; m_addr = '0; m_bank = '0; last_act = cyc;
        end else if (sb >= 0) begin
            m_valid = 1;
            m_cmd   = req_cmd[4*sb +: 4];
            m_addr  = req_addr[AW*sb +: AW];
            m_bank  = 3'(sb);
            m_rr    = (sb + 1) % NB;
            case (m_cmd)
                4'd6: last_act = cyc;
                4'd1: begin last_col = cyc; last_rd = cyc; end
                4'd2: begin last_col = cyc; last_wr = cyc; end
                default: ;
            endcase
        end else if (out_ready) begin
            m_valid = 0;
        end
        cyc++;
        #1;
    endtask

    int t1, t3, t5, t2, t4, t6;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_fields", {out_cmd, out_addr, out_bank}, 0);
        chk("rst_grants", {23'd0, ref_grant, req_grant}, 0);
        rst_n = 1'b1;

        // ACTIVE round robin on banks 1, 3, 5.
        set_req(1, 1, 4'd6, 24'h000111);
        set_req(3, 1, 4'd6, 24'h000333);
        set_req(5, 1, 4'd6, 24'h000555);
        t1 = -100; t3 = -100; t5 = -100;
        for (int i = 0; i < 14; i++) begin
            step();
            if (gnt_seen[1]) begin t1 = gcyc; req_valid[1] = 0; end
            if (gnt_seen[3]) begin t3 = gcyc; req_valid[3] = 0; end
            if (gnt_seen[5]) begin t5 = gcyc; req_valid[5] = 0; end
        end
        chk("act_first_cycle", 32'(t1), 0);
        chk("act_rrd_1_3", 32'(t3 - t1), 32'(T_RRD));
        chk("act_rrd_3_5", 32'(t5 - t3), 32'(T_RRD));

        // WRITE -> READ -> WRITE turnaround.
        set_req(2, 1, 4'd2, 24'h002222);
        set_req(4, 1, 4'd1, 24'h004444);
        t2 = -100; t4 = -100; t6 = -100;
        for (int i = 0; i < 24; i++) begin
            step();
            if (gnt_seen[2]) begin t2 = gcyc; req_valid[2] = 0; end
            if (gnt_seen[4]) begin t4 = gcyc; req_valid[4] = 0; set_req(6, 1, 4'd2, 24'h006666); end
            if (gnt_seen[6]) begin t6 = gcyc; req_valid[6] = 0; end
        end
        chk("wtr_gap", 32'(t4 - t2), 32'(T_WTR));
        chk("rtw_gap", 32'(t6 - t4), 32'(T_RTW));

        // PRECHARGE bypasses an active tRRD window.
        set_req(7, 1, 4'd6, 24'h007777);
        step();
        chk("act7_granted", 32'(gnt_seen[7]), 1);
        req_valid[7] = 0;
        set_req(0, 1, 4'd7, 24'h000abc);
        set_req(7, 1, 4'd6, 24'h007778);
        step();
        chk("pre_bypass", 32'(gnt_seen), 32'h01);
        req_valid[0] = 0;
        repeat (4) step();
        req_valid = '0;

        // Randomized traffic with backpressure, refresh and one mid-run reset.
        for (int i = 0; i < 700; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (i >= 200 && i < 210) out_ready = 1'b0;
            for (int b = 0; b < NB; b++)
                if (gnt_seen[b] || $urandom_range(0, 7) == 0)
                    set_req(b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 24'($urandom));
            if (ref_seen) ref_req = 1'b0;
            else if (!ref_req && $urandom_range(0, 39) == 0) ref_req = 1'b1;
            if (i == 400) begin
                #2 rst_n = 1'b0;
                #1;
                chk("midrst_out_valid", 32'(out_valid), 0);
                chk("midrst_out_fields", {out_cmd, out_addr, out_bank}, 0);
                chk("midrst_grants", {23'd0, ref_grant, req_grant}, 0);
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
                cyc++;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
